// File: rtl/adv7513_pkg.sv
// adv7513_pkg
// Shared definitions for the ADV7513 control blocks (adv7513_init,
// adv7513_reg_read, adv7513_int_handler): the fixed I2C slave address, the
// register map entries these blocks touch, and the interrupt handler states.
package adv7513_pkg;

    localparam logic [7:0] ADV7513_SLAVE_ADDR = 8'h72;  // 7-bit 0x39, write form
    localparam logic [7:0] ADV7513_INT_REG    = 8'h96;  // interrupt status, W1C
    localparam logic [7:0] ADV7513_HPD_REG    = 8'h42;  // HPD state register

    localparam int ADV7513_HPD_STATE_BIT = 6;  // HPD level inside HPD_REG
    localparam int ADV7513_HPD_INT_BIT   = 7;  // HPD change flag inside INT_REG

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_DEBOUNCE  = 3'd2,
        ST_READ_INT  = 3'd3,
        ST_WRITE_CLR = 3'd4,
        ST_READ_HPD  = 3'd5,
        ST_REINIT    = 3'd6
    } int_state_e;

endpackage

// File: rtl/int_debounce.sv
// int_debounce
// Synchronises the asynchronous active-low interrupt pin and counts how many
// consecutive cycles it has been seen low while the handler is listening.
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   int_n_i     raw interrupt pin, active-low, asynchronous
//   enable_i    handler is listening (IDLE/DEBOUNCE); counter held at 0 otherwise
//   int_low_o   synchronised pin is low
//   int_valid_o pin has been low for DEBOUNCE_CYCLES consecutive cycles,
//               counting the current one
module int_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic int_n_i,
    input  logic enable_i,
    output logic int_low_o,
    output logic int_valid_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter holds the number of low cycles already seen, so the current
    // low cycle completes the window when the count is one short of the target.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], int_n_i};
            cnt_q  <= cnt_d;
        end
    end

    assign int_low_o = ~sync_q[1];

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || !int_low_o) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign int_valid_o = int_low_o && enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/adv7513_int_handler.sv
// adv7513_int_handler
// Services the ADV7513 interrupt pin: after a debounced low level it reads the
// interrupt status register, writes the value back to clear it, and on an HPD
// change reads the HPD state, requesting a full re-init on a new plug-in.
//   clock / reset           system clock, asynchronous active-low reset
//   HDMI_TX_INT             ADV7513 interrupt pin (active-low, asynchronous)
//   init_done               adv7513_init has finished configuring the part
//   i2c_req .. i2c_wr_data  request to the shared I2C master (held until done)
//   i2c_done, i2c_rd_data,
//   i2c_ack_err             completion pulse from the I2C master
//   reinit_req              one-cycle pulse asking adv7513_init to run again
//   hpd_status, int_status  last successfully read HPD bit / interrupt status
//   int_count               interrupts fully handled (wraps)
//   err                     sticky I2C error, cleared by the next clean service
module adv7513_int_handler
    import adv7513_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR      = ADV7513_SLAVE_ADDR,
    parameter logic [7:0] INT_REG         = ADV7513_INT_REG,
    parameter logic [7:0] HPD_REG         = ADV7513_HPD_REG,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       HDMI_TX_INT,
    input  logic       init_done,
    output logic       i2c_req,
    output logic       i2c_rw,
    output logic [7:0] i2c_slave_addr,
    output logic [7:0] i2c_reg_addr,
    output logic [7:0] i2c_wr_data,
    input  logic       i2c_done,
    input  logic [7:0] i2c_rd_data,
    input  logic       i2c_ack_err,
    output logic       reinit_req,
    output logic       hpd_status,
    output logic [7:0] int_status,
    output logic [7:0] int_count,
    output logic       err
);

    int_state_e state_q, state_d;
    logic       req_q, req_d;
    logic       rw_q, rw_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic       reinit_q, reinit_d;
    logic       hpd_q, hpd_d;
    logic [7:0] ints_q, ints_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic listen;
    logic int_low;
    logic int_valid;

    // The debounce counter only runs while nothing is in flight, so pin
    // activity during an I2C transaction is ignored and a pin still low on
    // return to IDLE starts a fresh window.
    assign listen = (state_q == ST_IDLE) || (state_q == ST_DEBOUNCE);

    int_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i      (clock),
        .rst_ni     (reset),
        .int_n_i    (HDMI_TX_INT),
        .enable_i   (listen),
        .int_low_o  (int_low),
        .int_valid_o(int_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_WAIT_INIT;
            req_q    <= 1'b0;
            rw_q     <= 1'b0;
            reg_q    <= 8'h00;
            wdata_q  <= 8'h00;
            reinit_q <= 1'b0;
            hpd_q    <= 1'b0;
            ints_q   <= 8'h00;
            cnt_q    <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rw_q     <= rw_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            reinit_q <= reinit_d;
            hpd_q    <= hpd_d;
            ints_q   <= ints_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Transaction states raise i2c_req on the cycle they issue and drop it on
    // the done cycle, so back-to-back transactions always see one low cycle.
    // The read of INT_REG is issued on the same edge that enters READ_INT.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rw_d     = rw_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        reinit_d = 1'b0;
        hpd_d    = hpd_q;
        ints_d   = ints_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        unique case (state_q)
            ST_WAIT_INIT: begin
                if (init_done) state_d = ST_IDLE;
            end
            ST_IDLE, ST_DEBOUNCE: begin
                if (state_q == ST_IDLE && !init_done) begin
                    state_d = ST_WAIT_INIT;
                end else if (int_valid) begin
                    state_d = ST_READ_INT;
                    req_d   = 1'b1;
                    rw_d    = 1'b1;
                    reg_d   = INT_REG;
                    wdata_d = 8'h00;
                end else if (int_low) begin
                    state_d = ST_DEBOUNCE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_INT: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    rw_d    = 1'b1;
                    reg_d   = INT_REG;
                    wdata_d = 8'h00;
                end else if (i2c_done) begin
                    req_d = 1'b0;
                    if (i2c_ack_err) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ints_d  = i2c_rd_data;
                        state_d = ST_WRITE_CLR;
                    end
                end
            end
            ST_WRITE_CLR: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    rw_d    = 1'b0;
                    reg_d   = INT_REG;
                    wdata_d = ints_q;   // write-1-to-clear exactly what was seen
                end else if (i2c_done) begin
                    req_d = 1'b0;
                    if (i2c_ack_err) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        err_d   = 1'b0;
                        state_d = ints_q[ADV7513_HPD_INT_BIT] ? ST_READ_HPD : ST_IDLE;
                    end
                end
            end
            ST_READ_HPD: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    rw_d    = 1'b1;
                    reg_d   = HPD_REG;
                    wdata_d = 8'h00;
                end else if (i2c_done) begin
                    req_d = 1'b0;
                    if (i2c_ack_err) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        hpd_d = i2c_rd_data[ADV7513_HPD_STATE_BIT];
                        // Only a fresh plug-in needs the part reconfigured.
                        if (!hpd_q && i2c_rd_data[ADV7513_HPD_STATE_BIT]) begin
                            state_d  = ST_REINIT;
                            reinit_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_REINIT: begin
                state_d = ST_WAIT_INIT;
            end
            default: begin
                state_d = ST_WAIT_INIT;
            end
        endcase
    end

    assign i2c_req        = req_q;
    assign i2c_rw         = rw_q;
    assign i2c_slave_addr = SLAVE_ADDR;
    assign i2c_reg_addr   = reg_q;
    assign i2c_wr_data    = wdata_q;
    assign reinit_req     = reinit_q;
    assign hpd_status     = hpd_q;
    assign int_status     = ints_q;
    assign int_count      = cnt_q;
    assign err            = err_q;

endmodule

// File: tb/tb_adv7513_int_handler.sv
// tb_adv7513_int_handler
// Directed bench for adv7513_int_handler with a scripted I2C master that
// answers each request with a hand-chosen read value or acknowledge error.
module tb_adv7513_int_handler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       HDMI_TX_INT = 1'b1;
    logic       init_done = 1'b0;
    logic       i2c_req;
    logic       i2c_rw;
    logic [7:0] i2c_slave_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_wr_data;
    logic       i2c_done = 1'b0;
    logic [7:0] i2c_rd_data = 8'h00;
    logic       i2c_ack_err = 1'b0;
    logic       reinit_req;
    logic       hpd_status;
    logic [7:0] int_status;
    logic [7:0] int_count;
    logic       err;

    int tests = 0;
    int fails = 0;

    adv7513_int_handler #(
        .SLAVE_ADDR     (8'h72),
        .INT_REG        (8'h96),
        .HPD_REG        (8'h42),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .HDMI_TX_INT   (HDMI_TX_INT),
        .init_done     (init_done),
        .i2c_req       (i2c_req),
        .i2c_rw        (i2c_rw),
        .i2c_slave_addr(i2c_slave_addr),
        .i2c_reg_addr  (i2c_reg_addr),
        .i2c_wr_data   (i2c_wr_data),
        .i2c_done      (i2c_done),
        .i2c_rd_data   (i2c_rd_data),
        .i2c_ack_err   (i2c_ack_err),
        .reinit_req    (reinit_req),
        .hpd_status    (hpd_status),
        .int_status    (int_status),
        .int_count     (int_count),
        .err           (err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},    {7'd0, i2c_req},    8'h00);
        chk({tag, "_rw"},     {7'd0, i2c_rw},     8'h00);
        chk({tag, "_slave"},  i2c_slave_addr,     8'h72);
        chk({tag, "_reg"},    i2c_reg_addr,       8'h00);
        chk({tag, "_wd"},     i2c_wr_data,        8'h00);
        chk({tag, "_reinit"}, {7'd0, reinit_req}, 8'h00);
        chk({tag, "_hpd"},    {7'd0, hpd_status}, 8'h00);
        chk({tag, "_ints"},   int_status,         8'h00);
        chk({tag, "_cnt"},    int_count,          8'h00);
        chk({tag, "_err"},    {7'd0, err},        8'h00);
    endtask

    // Run n cycles and require that neither i2c_req nor reinit_req appears.
    task automatic quiet(input string tag, input int n);
        logic seen_req, seen_reinit;
        seen_req = 1'b0;
        seen_reinit = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i2c_req) seen_req = 1'b1;
            if (reinit_req) seen_reinit = 1'b1;
        end
        chk({tag, "_noreq"},    {7'd0, seen_req},    8'h00);
        chk({tag, "_noreinit"}, {7'd0, seen_reinit}, 8'h00);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (i2c_req !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_req_up"}, {7'd0, i2c_req}, 8'h01);
    endtask

    // Scripted I2C master: checks the request, holds it for two cycles,
    // answers with a done pulse and checks the request has dropped after it.
    task automatic serve(input string tag, input logic exp_rw, input logic [7:0] exp_reg,
                         input logic [7:0] exp_wd, input logic [7:0] rd, input logic ack);
        wait_req(tag);
        chk({tag, "_rw"},    {7'd0, i2c_rw}, {7'd0, exp_rw});
        chk({tag, "_slave"}, i2c_slave_addr, 8'h72);
        chk({tag, "_reg"},   i2c_reg_addr,   exp_reg);
        if (!exp_rw) chk({tag, "_wd"}, i2c_wr_data, exp_wd);
        tick();
        tick();
        chk({tag, "_hold"},     {7'd0, i2c_req}, 8'h01);
        chk({tag, "_reghold"},  i2c_reg_addr,    exp_reg);
        i2c_done = 1'b1;
        i2c_rd_data = rd;
        i2c_ack_err = ack;
        tick();
        i2c_done = 1'b0;
        i2c_rd_data = 8'h00;
        i2c_ack_err = 1'b0;
        chk({tag, "_drop"}, {7'd0, i2c_req}, 8'h00);
    endtask

    // One full interrupt without an HPD change: read returns v, write-back of v.
    task automatic irq_plain(input string tag, input logic [7:0] v);
        HDMI_TX_INT = 1'b0;
        serve({tag, "_rd"}, 1'b1, 8'h96, 8'h00, v, 1'b0);
        HDMI_TX_INT = 1'b1;
        serve({tag, "_wr"}, 1'b0, 8'h96, v, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check_reset("rst");

        // Released, init_done at cycle 10, pin idle for 1000 cycles
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        init_done = 1'b1;
        quiet("idle1000", 1000);
        check_reset("idle1000");

        // A done pulse with no request outstanding is ignored
        i2c_done = 1'b1;
        i2c_rd_data = 8'hFF;
        tick();
        i2c_done = 1'b0;
        i2c_rd_data = 8'h00;
        quiet("stray_done", 5);
        chk("stray_done_ints", int_status, 8'h00);

        // Glitch shorter than the debounce window
        HDMI_TX_INT = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        HDMI_TX_INT = 1'b1;
        quiet("short_low", 40);

        // Latency: read request appears 18 cycles after the fall
        begin
            logic early;
            early = 1'b0;
            HDMI_TX_INT = 1'b0;
            for (int i = 0; i < 17; i++) begin
                tick();
                if (i2c_req) early = 1'b1;
            end
            chk("lat_early", {7'd0, early}, 8'h00);
            tick();
            chk("lat18_req", {7'd0, i2c_req}, 8'h01);
        end

        // HPD plug-in: 0x80 then HPD bit set -> re-init
        serve("hpd_rd", 1'b1, 8'h96, 8'h00, 8'h80, 1'b0);
        HDMI_TX_INT = 1'b1;
        serve("hpd_wr", 1'b0, 8'h96, 8'h80, 8'h00, 1'b0);
        serve("hpd_hrd", 1'b1, 8'h42, 8'h00, 8'h40, 1'b0);
        chk("hpd_reinit",  {7'd0, reinit_req}, 8'h01);
        chk("hpd_status",  {7'd0, hpd_status}, 8'h01);
        chk("hpd_cnt",     int_count,          8'h01);
        chk("hpd_ints",    int_status,         8'h80);
        chk("hpd_err",     {7'd0, err},        8'h00);
        init_done = 1'b0;
        tick();
        chk("hpd_reinit_1cyc", {7'd0, reinit_req}, 8'h00);
        // Now waiting for init: the pin is not serviced
        HDMI_TX_INT = 1'b0;
        quiet("wait_init", 40);
        HDMI_TX_INT = 1'b1;
        tick();
        tick();
        tick();
        init_done = 1'b1;
        quiet("reinit_back", 5);

        // Non-HPD interrupt, pin held low across the write so a second one follows
        HDMI_TX_INT = 1'b0;
        serve("p4_rd", 1'b1, 8'h96, 8'h00, 8'h04, 1'b0);
        serve("p4_wr", 1'b0, 8'h96, 8'h04, 8'h00, 1'b0);
        chk("p4_cnt", int_count, 8'h02);
        serve("p4b_rd", 1'b1, 8'h96, 8'h00, 8'h04, 1'b0);
        HDMI_TX_INT = 1'b1;
        serve("p4b_wr", 1'b0, 8'h96, 8'h04, 8'h00, 1'b0);
        quiet("p4_nohpd", 30);
        chk("p4b_cnt",  int_count,          8'h03);
        chk("p4_ints",  int_status,         8'h04);
        chk("p4_hpd",   {7'd0, hpd_status}, 8'h01);

        // Acknowledge error on the status read
        HDMI_TX_INT = 1'b0;
        serve("ack_rd", 1'b1, 8'h96, 8'h00, 8'hAA, 1'b1);
        HDMI_TX_INT = 1'b1;
        chk("ack_err",  {7'd0, err}, 8'h01);
        chk("ack_ints", int_status,  8'h04);
        chk("ack_cnt",  int_count,   8'h03);
        quiet("ack_nowrite", 30);
        irq_plain("clean", 8'h01);
        chk("clean_err", {7'd0, err}, 8'h00);
        chk("clean_cnt", int_count,   8'h04);

        // Count up to 255, then wrap
        for (int i = 0; i < 251; i++) irq_plain("wrap", 8'h01);
        chk("cnt_255", int_count, 8'hFF);
        irq_plain("wrap_last", 8'h01);
        chk("cnt_wrap", int_count, 8'h00);

        // Reset while the HPD read is outstanding
        HDMI_TX_INT = 1'b0;
        serve("rst_rd", 1'b1, 8'h96, 8'h00, 8'h80, 1'b0);
        HDMI_TX_INT = 1'b1;
        serve("rst_wr", 1'b0, 8'h96, 8'h80, 8'h00, 1'b0);
        wait_req("rst_hrd");
        chk("rst_hrd_reg", i2c_reg_addr, 8'h42);
        reset = 1'b0;
        #1;
        chk("rst_req_drop", {7'd0, i2c_req}, 8'h00);
        tick();
        check_reset("rst_mid");
        reset = 1'b1;
        quiet("after_rst", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
